// File: rtl/bit_shift_pkg.sv
// Shared constants and helpers for the bit shifter / deserializer family.
package bit_shift_pkg;

   localparam string ARCH_BEHAVIORAL = "BEHAVIORAL";
   localparam string ARCH_VIRTEX5    = "VIRTEX5";
   localparam string ARCH_VIRTEX6    = "VIRTEX6";

   localparam int SHIFT_RIGHT = 1;
   localparam int SHIFT_LEFT  = 0;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/beat_counter.sv
// Modulo-BEATS beat counter with sync-to-zero and terminal-count outputs.
module beat_counter
   import bit_shift_pkg::*;
#(
   parameter int BEATS = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic i_step,
   input  logic i_sync,
   output logic o_tc,
   output logic o_last
);

   localparam int CW = (clog2(BEATS) < 1) ? 1 : clog2(BEATS);
   localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

   logic [CW-1:0] r_count;
   logic [CW-1:0] w_base;
   logic [CW-1:0] w_next;

   // A sync beat counts as beat 0 regardless of the stored position.
   always_comb begin
      w_base = i_sync ? '0 : r_count;
      o_last = (w_base == LAST);
      w_next = r_count;
      if (i_step) w_next = o_last ? '0 : w_base + CW'(1);
   end

   assign o_tc = (r_count == LAST);

   always_ff @(posedge clk) begin
      if (rst) r_count <= '0;
      else     r_count <= w_next;
   end

endmodule

// File: rtl/bit_deserializer.sv
// Collects W/N narrow beats into one W-bit word on a valid/ready output.
module bit_deserializer
   import bit_shift_pkg::*;
#(
   parameter string BLOCK_NAME        = "bit_deserializer",
   parameter int    X                 = 0,
   parameter int    Y                 = 0,
   parameter int    DX                = 0,
   parameter int    DY                = 0,
   parameter string ARCHITECTURE      = "BEHAVIORAL",
   parameter int    OUTPUT_DATA_WIDTH = 8,
   parameter int    NUMBER_BITS       = 1,
   parameter int    SHIFT_DIRECTION   = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUMBER_BITS-1:0]       data_in,
   input  logic                         data_in_valid,
   input  logic                         data_in_sync,
   output logic                         data_in_ready,
   output logic [OUTPUT_DATA_WIDTH-1:0] data_out,
   output logic                         data_out_valid,
   input  logic                         data_out_ready
);

   localparam int W     = OUTPUT_DATA_WIDTH;
   localparam int N     = NUMBER_BITS;
   localparam int BEATS = W / N;

   if (N < 1 || N > W || (W % N) != 0) begin : g_bad_width
      $error("bit_deserializer: width must be a multiple of beat width");
   end
   if (ARCHITECTURE != ARCH_BEHAVIORAL && ARCHITECTURE != ARCH_VIRTEX5 &&
       ARCHITECTURE != ARCH_VIRTEX6) begin : g_bad_arch
      $error("bit_deserializer: unknown architecture");
   end
   if (BLOCK_NAME == "" || X < 0 || Y < 0 || DX < 0 || DY < 0) begin : g_bad_diag
      $error("bit_deserializer: bad diagram name or geometry");
   end

   logic [W-1:0] r_shreg;
   logic [W-1:0] r_data_out;
   logic         r_data_out_valid;
   logic [W-1:0] w_next;
   logic         w_accept;
   logic         w_tc;
   logic         w_last;

   // Only a final beat can collide with a held word, so only it stalls.
   assign data_in_ready = !w_tc || !r_data_out_valid || data_out_ready;
   assign w_accept      = data_in_valid && data_in_ready;

   beat_counter #(
      .BEATS (BEATS)
   ) u_beat_counter (
      .clk    (clk),
      .rst    (rst),
      .i_step (w_accept),
      .i_sync (w_accept && data_in_sync),
      .o_tc   (w_tc),
      .o_last (w_last)
   );

   if (BEATS == 1) begin : g_single
      assign w_next = data_in;
   end else if (SHIFT_DIRECTION == SHIFT_RIGHT) begin : g_right
      assign w_next = {data_in, r_shreg[W-1:N]};
   end else begin : g_left
      assign w_next = {r_shreg[W-N-1:0], data_in};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_shreg          <= '0;
         r_data_out       <= '0;
         r_data_out_valid <= 1'b0;
      end else begin
         if (w_accept) r_shreg <= w_next;
         if (w_accept && w_last) begin
            r_data_out       <= w_next;
            r_data_out_valid <= 1'b1;
         end else if (data_out_ready) begin
            r_data_out_valid <= 1'b0;
         end
      end
   end

   assign data_out       = r_data_out;
   assign data_out_valid = r_data_out_valid;

endmodule
